// File: rtl/iid_tracker_if.sv
// Fetch/commit/flush bundle for the in-flight instruction-ID tracker, plus its observation outputs.
// The master drives requests; the slave (tracker) returns ready, ids, occupancy, trace and error state.
interface iid_tracker_if #(
    parameter int DEPTH    = 16,
    parameter int PC_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                alloc_valid;
    logic                alloc_ready;
    logic [PC_WIDTH-1:0] alloc_pc;
    logic [63:0]         alloc_iid;
    logic                commit_valid;
    logic [63:0]         commit_iid;
    logic                flush_valid;
    logic [63:0]         flush_iid;
    logic [CW-1:0]       inflight_count;
    logic [63:0]         oldest_iid;
    logic                trace_valid;
    logic [63:0]         trace_iid;
    logic [PC_WIDTH-1:0] trace_pc;
    logic                err;
    logic [63:0]         err_iid;

    modport master (
        output alloc_valid, alloc_pc, commit_valid, commit_iid, flush_valid, flush_iid,
        input  alloc_ready, alloc_iid, inflight_count, oldest_iid,
        input  trace_valid, trace_iid, trace_pc, err, err_iid
    );

    modport slave (
        input  alloc_valid, alloc_pc, commit_valid, commit_iid, flush_valid, flush_iid,
        output alloc_ready, alloc_iid, inflight_count, oldest_iid,
        output trace_valid, trace_iid, trace_pc, err, err_iid
    );
endinterface

// File: rtl/iid_tracker.sv
// Debug iid tracker: numbers fetched instructions, holds in-flight (iid, pc) in order, rolls back on flush.
// Commit trace appears one cycle after commit; alloc_ready drops when full or during a flush.
module iid_tracker #(
    parameter int DEPTH    = 16,
    parameter int PC_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    iid_tracker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]         mem_iid [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc  [DEPTH];

    logic [AW-1:0] head, tail, head_nxt, tail_nxt;
    logic [CW-1:0] count, count_nxt, keep;
    logic [63:0]   next_iid, next_iid_nxt;
    logic [63:0]   head_iid, flush_off;
    logic          empty, alloc_ready, push, pop;
    logic          commit_err, flush_hit, flush_err;

    logic                trace_valid;
    logic [63:0]         trace_iid;
    logic [PC_WIDTH-1:0] trace_pc;
    logic                err;
    logic [63:0]         err_iid;

    always_comb begin
        empty       = (count == '0);
        head_iid    = mem_iid[head];
        alloc_ready = (count < CW'(DEPTH)) && !bus.flush_valid;
        push        = bus.alloc_valid && alloc_ready;
        pop         = bus.commit_valid && !empty;
        commit_err  = bus.commit_valid && (empty || (bus.commit_iid != head_iid));

        // Range check is against the pre-commit head; the commit pop is applied after.
        flush_off   = bus.flush_iid - head_iid;
        flush_hit   = !empty && (flush_off < 64'(count));
        flush_err   = bus.flush_valid && !flush_hit;
        keep        = flush_hit ? (CW'(flush_off) + CW'(1)) : '0;

        head_nxt     = head + AW'(pop);
        count_nxt    = count;
        tail_nxt     = tail;
        next_iid_nxt = next_iid;
        if (bus.flush_valid) begin
            count_nxt    = (keep > CW'(pop)) ? (keep - CW'(pop)) : '0;
            // Survivors stay contiguous behind the new head.
            tail_nxt     = head_nxt + AW'(count_nxt);
            next_iid_nxt = bus.flush_iid + 64'd1;
        end else begin
            count_nxt    = count + CW'(push) - CW'(pop);
            tail_nxt     = tail + AW'(push);
            next_iid_nxt = push ? (next_iid + 64'd1) : next_iid;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_iid[tail] <= next_iid;
            mem_pc[tail]  <= bus.alloc_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            next_iid    <= '0;
            trace_valid <= 1'b0;
            trace_iid   <= '0;
            trace_pc    <= '0;
            err         <= 1'b0;
            err_iid     <= '0;
        end else begin
            head        <= head_nxt;
            tail        <= tail_nxt;
            count       <= count_nxt;
            next_iid    <= next_iid_nxt;
            trace_valid <= pop;
            if (pop) begin
                trace_iid <= head_iid;
                trace_pc  <= mem_pc[head];
            end
            // Only the first error is recorded; a commit error outranks a flush error.
            if (!err && (commit_err || flush_err)) begin
                err     <= 1'b1;
                err_iid <= commit_err ? bus.commit_iid : bus.flush_iid;
            end
        end
    end

    assign bus.alloc_ready    = alloc_ready;
    assign bus.alloc_iid      = next_iid;
    assign bus.inflight_count = count;
    assign bus.oldest_iid     = empty ? 64'd0 : head_iid;
    assign bus.trace_valid    = trace_valid;
    assign bus.trace_iid      = trace_iid;
    assign bus.trace_pc       = trace_pc;
    assign bus.err            = err;
    assign bus.err_iid        = err_iid;
endmodule

// File: doc/iid_tracker.md
Name: iid_tracker

Overview:
- Debug-only in-flight instruction-ID tracker that sits at fetch/commit and produces the per-instruction 64-bit `iid` values consumed by the iid package (`iid::Ty`, `inc`, `dec`).
- Assigns monotonically increasing iids to fetched instructions and keeps an in-order FIFO of in-flight (iid, pc) pairs.
- Rolls the FIFO back on pipeline flush and checks that commits retire iids in order.
- Emits a registered commit trace. Compiled only under `PRINT_DEBUGINFO`.

Parameters:
- DEPTH, 16, in-flight FIFO entries; power of two, ≥2.
- PC_WIDTH, 32, width of the stored fetch PC.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- alloc_valid  input  1  fetch requests an iid
- alloc_ready  output  1  tracker can accept an allocation
- alloc_pc  input  PC_WIDTH  PC of the fetched instruction
- alloc_iid  output  64  iid assigned on the handshake (= next_iid)
- commit_valid  input  1  one instruction commits this cycle
- commit_iid  input  64  iid of the committing instruction
- flush_valid  input  1  redirect; all instructions younger than flush_iid are killed
- flush_iid  input  64  iid of the redirecting instruction, which survives
- inflight_count  output  $clog2(DEPTH)+1  occupied entries
- oldest_iid  output  64  head iid; 0 when empty
- trace_valid  output  1  registered commit trace strobe
- trace_iid  output  64  iid of the traced commit
- trace_pc  output  PC_WIDTH  pc of the traced commit
- err  output  1  sticky protocol error
- err_iid  output  64  offending iid from the first error

Behaviour:
- **Reset** (async on rst_n low; outputs low or zero while asserted):
  - next_iid=0 (`iid::ZERO`), head=tail=0, count=0.
  - trace_valid=0, trace_iid=0, trace_pc=0, err=0, err_iid=0.
- **Allocation**:
  - alloc_ready = (count<DEPTH) && !flush_valid.
  - alloc_iid is combinational = next_iid.
  - Handshake (alloc_valid && alloc_ready): write {next_iid, alloc_pc} at tail, tail++, next_iid = `iid::inc` (wraps mod 2^64).
  - FIFO contents are always contiguous increasing iids from head_iid.
- **Commit** (commit_valid):
  - Non-empty and commit_iid==head_iid: pop head, then next cycle trace_valid=1 with trace_iid/trace_pc from the popped entry.
  - Non-empty and commit_iid≠head_iid: pop anyway, trace the popped entry, raise the error.
  - Empty: no pop, trace_valid=0 next cycle, raise the error.
  - trace_valid is otherwise 0; it is a 1-cycle pulse per commit.
- **Flush** (flush_valid):
  - Let off = flush_iid − head_iid (64-bit modular).
  - If off < count: keep = off+1; tail = head+keep; next_iid = flush_iid+1.
  - Otherwise (flush_iid not in flight): raise the error; FIFO becomes empty; next_iid = flush_iid+1.
  - Flush takes priority over allocation; alloc_ready is forced 0 that cycle.
- **Commit and flush in the same cycle**:
  - The commit pops the head first.
  - count' = keep − pop, saturating at 0. If commit_iid==flush_iid==head_iid, the result is empty.
  - Flush range checking uses the pre-commit head.
- **Count and pointers**:
  - count' = count + push − pop, or per the flush rule.
  - Pointers wrap mod DEPTH.
  - A simultaneous alloc and commit on a full FIFO is not accepted, because alloc_ready=0.
- **Errors**:
  - err is set on the first error and is never cleared except by reset.
  - err_iid captures commit_iid (commit error) or flush_iid (flush error) from the first error only.
  - If both error in the same cycle, the commit error wins.
- oldest_iid = head entry iid when count>0, else 0.
- No other latency. alloc_iid, alloc_ready, oldest_iid and inflight_count are combinational from state.

Test Plan:
- **Reset then allocations:** reset, then 3 allocs with pc 0x100/0x104/0x108 → alloc_iid 0,1,2; inflight_count=3; oldest_iid=0.
- **Fill to full:** fill to 16 → alloc_ready=0. Commit iid 0 → count 15, next cycle trace_valid=1, trace_iid=0, trace_pc=0x100. Then alloc_ready=1.
- **Flush truncation:** with iids 0..9 in flight, flush_iid=4 → count=5; next alloc_iid=5; oldest_iid=0; no err.
- **Simultaneous commit and flush:** with iids 3..6 in flight, commit_iid=3 and flush_iid=3 in the same cycle → count=0, trace_iid=3, next alloc_iid=4.
- **Order violation:** with iids 0..2 in flight, commit_iid=1 → entry 0 popped and traced, err=1, err_iid=1. A later commit on an empty FIFO leaves err_iid=1.
- **Reset mid-operation:** assert rst_n=0 mid-stream with 5 in flight and trace_valid high → all outputs clear immediately; after release, alloc_iid=0 and inflight_count=0.
